muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter Width, default 32, datapath and operand width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, request to begin one operation.
REQ-005 SHALL have port Funct3, input, 3, RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have ports RegReadData1 and RegReadData2, input, Width each, rs1 and rs2 operands from the register file read ports.
REQ-007 SHALL have port Rd, input, 5, destination register index.
REQ-008 SHALL have port Busy, output, 1, unit is occupied; Start is ignored while high.
REQ-009 SHALL have port Done, output, 1, one-cycle completion strobe.
REQ-010 SHALL have port Result, output, Width, operation result.
REQ-011 SHALL have ports RegWrite (output, 1) and WriteDataTrig (output, 5), register-file write strobe and write index; Result drives register-file WD1.

Function
REQ-012 SHALL use states IDLE, RUN and FINISH.
REQ-013 SHALL accept Start only in IDLE, latching Funct3, both operands and Rd on the accepting edge, and SHALL then move to RUN.
REQ-014 SHALL assert Busy in RUN and FINISH, and deassert it in IDLE.
REQ-015 SHALL, in RUN, perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on operand magnitudes for exactly Width cycles, then move to FINISH.
REQ-016 SHALL assert Done for exactly one cycle, in FINISH, Width+1 cycles after the accepting edge, then return to IDLE.
REQ-017 SHALL apply result sign correction in the transition to FINISH: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned; MUL returns the low Width bits; the REM sign follows the dividend.
REQ-018 SHALL, on divide by zero, return all-ones for DIV/DIVU and rs1 for REM/REMU, with RUN skipped and Done one cycle after accept.
REQ-019 SHALL, on signed overflow (rs1 = most-negative, rs2 = -1), return rs1 for DIV and 0 for REM, with Done one cycle after accept.
REQ-020 SHALL assert RegWrite in the Done cycle with WriteDataTrig = latched Rd, except when Rd = 0, in which case RegWrite stays low and Done still pulses.
REQ-021 SHALL hold Result and WriteDataTrig stable from Done until the next accepted Start.
REQ-022 SHALL ignore a Start coincident with Done; such a Start must be re-presented once Busy is low.

Reset
REQ-023 SHALL, under reset, force state IDLE and Busy, Done, RegWrite, Result and WriteDataTrig to 0.
REQ-024 SHALL, on reset mid-operation, abort the operation with no Done or RegWrite for it, and SHALL accept a new Start on the first edge with reset low.

Configuration
REQ-025 SHALL, when macro MULDIV_FAST_MUL_EN is defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle 2*Width-bit product: RUN is skipped, Done comes one cycle after accept, and divides stay iterative.
REQ-026 SHALL, when MULDIV_FAST_MUL_EN is undefined, make all eight ops iterative per REQ-015/016.

Structure
REQ-027 SHALL place the Funct3 op encodings, the state enum and the Width default in shared package muldiv_pkg.
REQ-028 SHALL place the per-cycle shift-add/subtract datapath (accumulator, quotient, counter) in sub-module muldiv_iter, with the FSM, special cases and writeback in muldiv_unit.

Verification
REQ-029 SHALL cover: MUL with rs1=7, rs2=6, Rd=5 -> Done at cycle 33 after accept, Result=42, RegWrite=1, WriteDataTrig=5.
REQ-030 SHALL cover: MULH with rs1=0x80000000, rs2=0x80000000 -> Result=0x40000000; MULHSU with rs1=0xFFFFFFFF (-1), rs2=2 -> Result=0xFFFFFFFF.
REQ-031 SHALL cover: DIV with rs1=-7, rs2=2 -> Result=0xFFFFFFFD; REM with the same operands -> Result=0xFFFFFFFF.
REQ-032 SHALL cover: DIVU by 0 with rs1=9 -> Result=0xFFFFFFFF and Done 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> Result=0x80000000.
REQ-033 SHALL cover: Start during Busy and Start coincident with Done -> both ignored; Rd=0 -> Done pulses with RegWrite=0.
REQ-034 SHALL cover: reset at cycle 10 of a DIVU -> no Done; a new MULU accepted the cycle after reset falls completes correctly; all cases repeated with MULDIV_FAST_MUL_EN defined, where MUL Done comes 1 cycle after accept.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Op encodings, FSM states, default width and signedness helpers.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic logic signed_a(op_e op);
        return op == OP_MULH || op == OP_MULHSU ||
               op == OP_DIV  || op == OP_REM;
    endfunction

    function automatic logic signed_b(op_e op);
        return op == OP_MULH || op == OP_DIV || op == OP_REM;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply / restoring divide.
// hi/lo hold {acc,multiplier} for mul and {remainder,quotient} for div.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int Width = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic [Width-1:0] hi_nx,
    output logic [Width-1:0] lo_nx,
    output logic             last
);

    localparam int CW = $clog2(Width);

    logic [Width-1:0] hi, lo, bq;
    logic             div_q;
    logic [CW-1:0]    cnt;
    logic [Width:0]   sum, t;
    logic [Width-1:0] diff;
    logic             ge;

    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
        t     = {hi, lo[Width-1]};
        ge    = t >= {1'b0, bq};
        // remainder after subtract is < divisor, so W bits suffice
        diff  = t[Width-1:0] - bq;
        hi_nx = sum[Width:1];
        lo_nx = {sum[0], lo[Width-1:1]};
        if (div_q) begin
            hi_nx = ge ? diff : t[Width-1:0];
            lo_nx = {lo[Width-2:0], ge};
        end
    end

    assign last = cnt == CW'(Width - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            bq    <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            hi    <= '0;
            lo    <= a;
            bq    <= b;
            div_q <= is_div;
            cnt   <= '0;
        end else if (step) begin
            hi    <= hi_nx;
            lo    <= lo_nx;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with FSM, special cases and writeback.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int Width = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [Width-1:0] RegReadData1,
    input  logic [Width-1:0] RegReadData2,
    input  logic [4:0]       Rd,
    output logic             Busy,
    output logic             Done,
    output logic [Width-1:0] Result,
    output logic             RegWrite,
    output logic [4:0]       WriteDataTrig
);

    localparam logic [Width-1:0] MINV = {1'b1, {(Width-1){1'b0}}};

    state_e           state, state_nx;
    op_e              op_i, op_q;
    logic             na_i, nb_i, na_q, nb_q;
    logic [4:0]       rd_q;
    logic             accept, dz, ovf, fast, quick, last;
    logic [Width-1:0] am, bm, quick_res, hi_nx, lo_nx;

    function automatic logic [Width-1:0] fix(
        op_e op, logic na, logic nb, logic [2*Width-1:0] p
    );
        logic [2*Width-1:0] sp;
        logic [Width-1:0]   q, r;
        sp = (na ^ nb) ? -p : p;
        q  = (na ^ nb) ? -p[Width-1:0] : p[Width-1:0];
        r  = na ? -p[2*Width-1:Width] : p[2*Width-1:Width];
        unique case (op)
            OP_MUL:                        return sp[Width-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  return sp[2*Width-1:Width];
            OP_DIV, OP_DIVU:               return q;
            default:                       return r;
        endcase
    endfunction

    assign op_i   = op_e'(Funct3);
    assign accept = Start && state == IDLE;
    assign na_i   = signed_a(op_i) && RegReadData1[Width-1];
    assign nb_i   = signed_b(op_i) && RegReadData2[Width-1];
    assign am     = na_i ? -RegReadData1 : RegReadData1;
    assign bm     = nb_i ? -RegReadData2 : RegReadData2;
    assign dz     = Funct3[2] && RegReadData2 == '0;
    assign ovf    = (op_i == OP_DIV || op_i == OP_REM) &&
                    RegReadData1 == MINV && RegReadData2 == '1;
    assign quick  = dz || ovf || fast;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*Width-1:0] prod;
    assign prod = {{Width{1'b0}}, am} * {{Width{1'b0}}, bm};
    assign fast = !Funct3[2];
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        quick_res = '0;
        if (dz)
            quick_res = (op_i == OP_DIV || op_i == OP_DIVU) ? '1 : RegReadData1;
        else if (ovf)
            quick_res = (op_i == OP_DIV) ? RegReadData1 : '0;
`ifdef MULDIV_FAST_MUL_EN
        else if (fast)
            quick_res = fix(op_i, na_i, nb_i, prod);
`endif
    end

    muldiv_iter #(.Width(Width)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (state == RUN),
        .is_div (Funct3[2]),
        .a      (am),
        .b      (bm),
        .hi_nx  (hi_nx),
        .lo_nx  (lo_nx),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = quick ? FINISH : RUN;
            RUN:     if (last)   state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy     = state != IDLE;
        Done     = state == FINISH;
        RegWrite = state == FINISH && rd_q != 5'd0;
    end

    // sign correction lands on the same edge that enters FINISH
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= OP_MUL;
            na_q   <= 1'b0;
            nb_q   <= 1'b0;
            rd_q   <= '0;
            Result <= '0;
        end else begin
            if (accept) begin
                op_q <= op_i;
                na_q <= na_i;
                nb_q <= nb_i;
                rd_q <= Rd;
            end
            if (accept && quick)
                Result <= quick_res;
            else if (state == RUN && last)
                Result <= fix(op_q, na_q, nb_q, {hi_nx, lo_nx});
        end
    end

    assign WriteDataTrig = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: fixed vectors, corner sequences
// and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] RegReadData1 = '0;
    logic [31:0] RegReadData2 = '0;
    logic [4:0]  Rd = '0;
    logic        Busy, Done, RegWrite;
    logic [31:0] Result;
    logic [4:0]  WriteDataTrig;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.Width(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .Start         (Start),
        .Funct3        (Funct3),
        .RegReadData1  (RegReadData1),
        .RegReadData2  (RegReadData2),
        .Rd            (Rd),
        .Busy          (Busy),
        .Done          (Done),
        .Result        (Result),
        .RegWrite      (RegWrite),
        .WriteDataTrig (WriteDataTrig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [2:0] op,
                                          logic [31:0] a, logic [31:0] b);
        logic signed [65:0] sa, sb, ua, ub, p;
        int ia, ib;
        logic ovf;
        sa  = {{34{a[31]}}, a};
        sb  = {{34{b[31]}}, b};
        ua  = {34'd0, a};
        ub  = {34'd0, b};
        ia  = a;
        ib  = b;
        ovf = a == MINV && b == 32'hFFFF_FFFF;
        p   = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(logic [2:0] op,
                                   logic [31:0] a, logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MINV && b == 32'hFFFF_FFFF)
            return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic junk_start();
        Start        = 1'b1;
        Funct3       = 3'($urandom);
        RegReadData1 = $urandom;
        RegReadData2 = $urandom;
        Rd           = 5'($urandom);
    endtask

    // Call at #1 after an edge with the unit idle. poke>0 presents a
    // stray Start at that cycle while busy and also at the Done cycle.
    task automatic do_op(input string nm, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input int poke);
        int n;
        logic [31:0] res;
        Start = 1'b1; Funct3 = op; RegReadData1 = a;
        RegReadData2 = b; Rd = rd;
        @(posedge clk); #1;
        Start = 1'b0;
        RegReadData1 = $urandom; RegReadData2 = $urandom;
        Rd = 5'($urandom);
        n = 1;
        while (!Done && n < 40) begin
            if (poke != 0 && n == poke) junk_start();
            @(posedge clk); #1;
            Start = 1'b0;
            n++;
        end
        chk({nm, " latency"}, Done ? n : 0, exp_lat(op, a, b));
        chk({nm, " result"}, Result, exp);
        chk({nm, " regwrite"}, 32'(RegWrite), 32'(rd != 0));
        chk({nm, " wdt"}, 32'(WriteDataTrig), 32'(rd));
        res = Result;
        if (poke != 0) junk_start();
        @(posedge clk); #1;
        Start = 1'b0;
        chk({nm, " done one cycle"}, 32'(Done), 32'd0);
        chk({nm, " idle after"}, 32'(Busy), 32'd0);
        chk({nm, " result held"}, Result, res);
        chk({nm, " wdt held"}, 32'(WriteDataTrig), 32'(rd));
    endtask

    initial begin
        tbl[0]  = '{3'd0, 32'd7,         32'd6,         5'd5,  32'd42};
        tbl[1]  = '{3'd1, MINV,          MINV,          5'd1,  32'h4000_0000};
        tbl[2]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd2,  32'hFFFF_FFFF};
        tbl[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFD};
        tbl[4]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFF};
        tbl[5]  = '{3'd5, 32'd9,         32'd0,         5'd6,  32'hFFFF_FFFF};
        tbl[6]  = '{3'd4, MINV,          32'hFFFF_FFFF, 5'd7,  MINV};
        tbl[7]  = '{3'd6, MINV,          32'hFFFF_FFFF, 5'd8,  32'd0};
        tbl[8]  = '{3'd7, 32'd9,         32'd0,         5'd9,  32'd9};
        tbl[9]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE};
        tbl[10] = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14};
        tbl[11] = '{3'd7, 32'd100,       32'd7,         5'd0,  32'd2};
        tbl[12] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd31, 32'd1};
        tbl[13] = '{3'd4, 32'd0,         32'd0,         5'd0,  32'hFFFF_FFFF};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset regwrite", 32'(RegWrite), 32'd0);
        chk("reset result", Result, 32'd0);
        chk("reset wdt", 32'(WriteDataTrig), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].rd, tbl[i].exp, 0);

        do_op("busy start", 3'd5, 32'd1000, 32'd3, 5'd12, 32'd333, 5);
        do_op("busy start dz", 3'd4, 32'd5, 32'd0, 5'd13,
              32'hFFFF_FFFF, 3);

        // reset ten cycles into a DIVU, then restart immediately
        Start = 1'b1; Funct3 = 3'd5; RegReadData1 = 32'd12345;
        RegReadData2 = 32'd11; Rd = 5'd14;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("pre-reset busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort done", 32'(Done), 32'd0);
        chk("abort regwrite", 32'(RegWrite), 32'd0);
        chk("abort result", Result, 32'd0);
        chk("abort wdt", 32'(WriteDataTrig), 32'd0);
        reset = 1'b0;
        do_op("after reset mulhu", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0,
              5'd15, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          mode;
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 32'd0;
                1: begin a = MINV; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 15);
                4: b = -($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d op%0d", i, op), op, a, b,
                  5'($urandom_range(0, 31)), model(op, a, b),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
